// File: rtl/haz_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select codes, multi-cycle
// FSM states and the stage packets used by the match logic.
package haz_pkg;

    // Register indices are zero-extended into packets, so REG_W must not exceed this.
    localparam int REG_W_MAX = 8;

    typedef logic [REG_W_MAX-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    typedef struct packed {
        logic     vld;
        reg_idx_t idx;
    } src_pkt_t;

    typedef struct packed {
        logic     vld;
        logic     is_load;
        reg_idx_t idx;
    } wr_pkt_t;

    // Register 0 is hard-wired zero and never produces a hazard or a forward.
    function automatic logic reg_match(src_pkt_t s, wr_pkt_t w);
        return s.vld & w.vld & (s.idx == w.idx) & (s.idx != '0);
    endfunction

endpackage

// File: rtl/haz_fwd_if.sv
// Decode-side bus between the pipeline (master) and the hazard unit (slave).
interface haz_fwd_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 4
);
    logic [NUM_SRC-1:0]       dec_src_vld;
    logic [NUM_SRC*REG_W-1:0] dec_src_reg;
    logic                     dec_mc_op;
    logic                     ex_dst_vld;
    logic [REG_W-1:0]         ex_dst_reg;
    logic                     ex_is_load;
    logic                     mem_dst_vld;
    logic [REG_W-1:0]         mem_dst_reg;
    logic                     wb_dst_vld;
    logic [REG_W-1:0]         wb_dst_reg;
    logic                     mem_jmp_vld;
    logic                     mc_issue;
    logic [REG_W-1:0]         mc_dst;
    logic [LAT_W-1:0]         mc_lat;
    logic                     stall;
    logic                     dec_bubble;
    logic                     ex_bubble;
    logic [NUM_SRC*2-1:0]     fwd_sel;
    logic                     mc_busy;
    logic                     mc_done;

    modport master (
        output dec_src_vld, dec_src_reg, dec_mc_op,
        output ex_dst_vld, ex_dst_reg, ex_is_load,
        output mem_dst_vld, mem_dst_reg, wb_dst_vld, wb_dst_reg,
        output mem_jmp_vld, mc_issue, mc_dst, mc_lat,
        input  stall, dec_bubble, ex_bubble, fwd_sel, mc_busy, mc_done
    );

    modport slave (
        input  dec_src_vld, dec_src_reg, dec_mc_op,
        input  ex_dst_vld, ex_dst_reg, ex_is_load,
        input  mem_dst_vld, mem_dst_reg, wb_dst_vld, wb_dst_reg,
        input  mem_jmp_vld, mc_issue, mc_dst, mc_lat,
        output stall, dec_bubble, ex_bubble, fwd_sel, mc_busy, mc_done
    );

endinterface

// File: rtl/haz_mc_sb.sv
// Multi-cycle unit scoreboard: tracks the single in-flight mul/div op, counts
// down its latency and remembers its destination register.
module haz_mc_sb
    import haz_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mc_issue,
    input  logic             i_mem_jmp_vld,
    input  logic [REG_W-1:0] i_mc_dst,
    input  logic [LAT_W-1:0] i_mc_lat,
    output logic             o_mc_busy,
    output logic             o_mc_done,
    output logic [REG_W-1:0] o_busy_dst
);

    mc_state_e        r_state;
    mc_state_e        w_state_next;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_next;
    logic [REG_W-1:0] r_dst;
    logic [REG_W-1:0] w_dst_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dst   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dst   <= w_dst_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dst_next   = r_dst;
        o_mc_busy    = 1'b0;
        o_mc_done    = 1'b0;
        case (r_state)
            IDLE: begin
                // A jump resolving in the same cycle squashes the younger op.
                if (i_mc_issue && !i_mem_jmp_vld) begin
                    w_state_next = BUSY;
                    w_cnt_next   = (i_mc_lat == '0) ? LAT_W'(1) : i_mc_lat;
                    w_dst_next   = i_mc_dst;
                end
            end
            BUSY: begin
                o_mc_busy = 1'b1;
                if (r_cnt == LAT_W'(1)) begin
                    o_mc_done    = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy_dst = r_dst;

    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(i_mc_issue && (r_state == BUSY))
    );

endmodule

// File: rtl/haz_fwd.sv
// Hazard unit beside decode: forward selects, load-use / multi-cycle stalls and
// the post-jump flush bubble.
module haz_fwd
    import haz_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_EN    = 1,
    parameter int LAT_W     = 4,
    parameter int FLUSH_CYC = 1
) (
    input logic     clk,
    input logic     rst_n,
    haz_fwd_if.slave bus
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic [FC_W-1:0]  r_fcnt;
    logic             w_bubble;
    logic             w_raw_stall;
    logic             w_mc_busy;
    logic             w_mc_done;
    logic [REG_W-1:0] w_busy_dst;
    logic [NUM_SRC-1:0] w_src_stall;
    fwd_sel_e         w_sel [NUM_SRC];
    wr_pkt_t          w_ex;
    wr_pkt_t          w_mem;
    wr_pkt_t          w_wb;
    wr_pkt_t          w_mc;

    haz_mc_sb #(
        .REG_W (REG_W),
        .LAT_W (LAT_W)
    ) u_mc_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mc_issue    (bus.mc_issue),
        .i_mem_jmp_vld (bus.mem_jmp_vld),
        .i_mc_dst      (bus.mc_dst),
        .i_mc_lat      (bus.mc_lat),
        .o_mc_busy     (w_mc_busy),
        .o_mc_done     (w_mc_done),
        .o_busy_dst    (w_busy_dst)
    );

    // Reloading on every jump lets back-to-back jumps extend the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (bus.mem_jmp_vld) begin
            r_fcnt <= FC_W'(FLUSH_CYC - 1);
        end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    assign w_ex  = '{vld: bus.ex_dst_vld,  is_load: bus.ex_is_load, idx: reg_idx_t'(bus.ex_dst_reg)};
    assign w_mem = '{vld: bus.mem_dst_vld, is_load: 1'b0,           idx: reg_idx_t'(bus.mem_dst_reg)};
    assign w_wb  = '{vld: bus.wb_dst_vld,  is_load: 1'b0,           idx: reg_idx_t'(bus.wb_dst_reg)};
    assign w_mc  = '{vld: w_mc_busy,       is_load: 1'b0,           idx: reg_idx_t'(w_busy_dst)};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            src_pkt_t w_src;
            logic     w_m_ex;
            logic     w_m_mem;
            logic     w_m_wb;
            logic     w_m_mc;

            assign w_src   = '{vld: bus.dec_src_vld[gi], idx: reg_idx_t'(bus.dec_src_reg[gi*REG_W +: REG_W])};
            assign w_m_ex  = reg_match(w_src, w_ex);
            assign w_m_mem = reg_match(w_src, w_mem);
            assign w_m_wb  = reg_match(w_src, w_wb);
            assign w_m_mc  = reg_match(w_src, w_mc);

            if (FWD_EN != 0) begin : g_fwd
                // A load in EX has no data yet, so its select is irrelevant while stalled.
                assign w_src_stall[gi] = (w_m_ex & bus.ex_is_load) | w_m_mc;
                assign w_sel[gi] = w_m_ex  ? FWD_EX  :
                                   w_m_mem ? FWD_MEM :
                                   w_m_wb  ? FWD_WB  : FWD_RF;
            end else begin : g_legacy
                assign w_src_stall[gi] = w_m_ex | w_m_mem | w_m_wb | w_m_mc;
                assign w_sel[gi]       = FWD_RF;
            end

            assign bus.fwd_sel[gi*2 +: 2] = w_sel[gi];
        end
    endgenerate

    assign w_raw_stall    = (|w_src_stall) | (w_mc_busy & bus.dec_mc_op);
    assign w_bubble       = bus.mem_jmp_vld | (r_fcnt != '0);
    assign bus.stall      = w_raw_stall & ~w_bubble;
    assign bus.dec_bubble = w_bubble;
    assign bus.ex_bubble  = w_bubble;
    assign bus.mc_busy    = w_mc_busy;
    assign bus.mc_done    = w_mc_done;

endmodule

// File: tb/tb_haz_fwd.sv
// Directed scoreboard bench: forwarding build (FLUSH_CYC=3) and legacy stall-only
// build driven by the same stimulus; expectations are queued and checked at negedge.
module tb_haz_fwd;

    logic       clk;
    logic       rst_n;
    logic [1:0] t_src_vld;
    logic [9:0] t_src_reg;
    logic       t_mc_op;
    logic       t_ex_vld;
    logic [4:0] t_ex_reg;
    logic       t_ex_ld;
    logic       t_mem_vld;
    logic [4:0] t_mem_reg;
    logic       t_wb_vld;
    logic [4:0] t_wb_reg;
    logic       t_jmp;
    logic       t_issue;
    logic [4:0] t_mc_dst;
    logic [3:0] t_mc_lat;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic       bub;
        logic [3:0] fwd;
        bit         chk_fwd;
        logic       busy;
        logic       done;
        logic       lstall;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    haz_fwd_if #(.REG_W(5), .NUM_SRC(2), .LAT_W(4)) bus_m ();
    haz_fwd_if #(.REG_W(5), .NUM_SRC(2), .LAT_W(4)) bus_l ();

    haz_fwd #(.REG_W(5), .NUM_SRC(2), .FWD_EN(1), .LAT_W(4), .FLUSH_CYC(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    haz_fwd #(.REG_W(5), .NUM_SRC(2), .FWD_EN(0), .LAT_W(4), .FLUSH_CYC(1)) u_dut_legacy (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    assign bus_m.dec_src_vld = t_src_vld;  assign bus_l.dec_src_vld = t_src_vld;
    assign bus_m.dec_src_reg = t_src_reg;  assign bus_l.dec_src_reg = t_src_reg;
    assign bus_m.dec_mc_op   = t_mc_op;    assign bus_l.dec_mc_op   = t_mc_op;
    assign bus_m.ex_dst_vld  = t_ex_vld;   assign bus_l.ex_dst_vld  = t_ex_vld;
    assign bus_m.ex_dst_reg  = t_ex_reg;   assign bus_l.ex_dst_reg  = t_ex_reg;
    assign bus_m.ex_is_load  = t_ex_ld;    assign bus_l.ex_is_load  = t_ex_ld;
    assign bus_m.mem_dst_vld = t_mem_vld;  assign bus_l.mem_dst_vld = t_mem_vld;
    assign bus_m.mem_dst_reg = t_mem_reg;  assign bus_l.mem_dst_reg = t_mem_reg;
    assign bus_m.wb_dst_vld  = t_wb_vld;   assign bus_l.wb_dst_vld  = t_wb_vld;
    assign bus_m.wb_dst_reg  = t_wb_reg;   assign bus_l.wb_dst_reg  = t_wb_reg;
    assign bus_m.mem_jmp_vld = t_jmp;      assign bus_l.mem_jmp_vld = t_jmp;
    assign bus_m.mc_issue    = t_issue;    assign bus_l.mc_issue    = t_issue;
    assign bus_m.mc_dst      = t_mc_dst;   assign bus_l.mc_dst      = t_mc_dst;
    assign bus_m.mc_lat      = t_mc_lat;   assign bus_l.mc_lat      = t_mc_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        t_src_vld = '0; t_src_reg = '0; t_mc_op = 1'b0;
        t_ex_vld = 1'b0; t_ex_reg = '0; t_ex_ld = 1'b0;
        t_mem_vld = 1'b0; t_mem_reg = '0; t_wb_vld = 1'b0; t_wb_reg = '0;
        t_jmp = 1'b0; t_issue = 1'b0; t_mc_dst = '0; t_mc_lat = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic set_src(input int i, input logic [4:0] r);
        t_src_vld[i] = 1'b1;
        t_src_reg[i*5 +: 5] = r;
    endtask

    task automatic push(input string tag, input logic e_stall, input logic e_bub,
                        input logic [3:0] e_fwd, input bit e_chk_fwd,
                        input logic e_busy, input logic e_done, input logic e_lstall);
        exp_t e;
        e.tag = tag; e.stall = e_stall; e.bub = e_bub; e.fwd = e_fwd; e.chk_fwd = e_chk_fwd;
        e.busy = e_busy; e.done = e_done; e.lstall = e_lstall;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "/stall"},  bus_m.stall,      mon_e.stall);
            check({mon_e.tag, "/decbub"}, bus_m.dec_bubble, mon_e.bub);
            check({mon_e.tag, "/exbub"},  bus_m.ex_bubble,  mon_e.bub);
            if (mon_e.chk_fwd) check({mon_e.tag, "/fwd"}, bus_m.fwd_sel, mon_e.fwd);
            check({mon_e.tag, "/busy"},   bus_m.mc_busy,    mon_e.busy);
            check({mon_e.tag, "/done"},   bus_m.mc_done,    mon_e.done);
            check({mon_e.tag, "/lstall"}, bus_l.stall,      mon_e.lstall);
            check({mon_e.tag, "/lfwd"},   bus_l.fwd_sel,    0);
            $display("txn %-12s stall=%0b bub=%0b fwd=%h busy=%0b done=%0b lstall=%0b",
                     mon_e.tag, bus_m.stall, bus_m.dec_bubble, bus_m.fwd_sel,
                     bus_m.mc_busy, bus_m.mc_done, bus_l.stall);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        push("reset", 0, 0, 4'h0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding priority and select encoding
        cyc(); set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; t_mem_vld = 1; t_mem_reg = 3;
        push("f_ex", 0, 0, 4'h1, 1, 0, 0, 1);
        cyc(); set_src(0, 5'd3); t_mem_vld = 1; t_mem_reg = 3;
        push("f_mem", 0, 0, 4'h2, 1, 0, 0, 1);
        cyc(); set_src(0, 5'd3); t_wb_vld = 1; t_wb_reg = 3;
        push("f_wb", 0, 0, 4'h3, 1, 0, 0, 1);
        cyc(); set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; set_src(1, 5'd7); t_wb_vld = 1; t_wb_reg = 7;
        push("f_mix", 0, 0, 4'hD, 1, 0, 0, 1);
        cyc(); t_src_reg[4:0] = 5'd3; t_ex_vld = 1; t_ex_reg = 3;
        push("f_novld", 0, 0, 4'h0, 1, 0, 0, 0);

        // Load-use, register zero and legacy stall
        cyc(); set_src(1, 5'd8); t_ex_vld = 1; t_ex_reg = 8; t_ex_ld = 1;
        push("ld_use", 1, 0, 4'h0, 0, 0, 0, 1);
        cyc(); set_src(1, 5'd0); t_ex_vld = 1; t_ex_reg = 0; t_ex_ld = 1;
        push("ld_r0", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc(); set_src(1, 5'd8); t_mem_vld = 1; t_mem_reg = 8;
        push("leg_mem", 0, 0, 4'h8, 1, 0, 0, 1);

        // Multi-cycle op, latency 4
        cyc(); t_issue = 1; t_mc_dst = 5; t_mc_lat = 4;
        push("mc_issue", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc(); set_src(0, 5'd5);
        push("mc_b1", 1, 0, 4'h0, 1, 1, 0, 1);
        cyc(); t_mc_op = 1;
        push("mc_b2", 1, 0, 4'h0, 1, 1, 0, 1);
        cyc(); set_src(0, 5'd6);
        push("mc_b3", 0, 0, 4'h0, 1, 1, 0, 0);
        cyc(); set_src(0, 5'd5);
        push("mc_b4", 1, 0, 4'h0, 1, 1, 1, 1);
        cyc(); set_src(0, 5'd5);
        push("mc_after", 0, 0, 4'h0, 1, 0, 0, 0);

        // Zero latency behaves as one cycle
        cyc(); t_issue = 1; t_mc_dst = 9; t_mc_lat = 0;
        push("lat0_issue", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc();
        push("lat0_busy", 0, 0, 4'h0, 1, 1, 1, 0);
        cyc();
        push("lat0_after", 0, 0, 4'h0, 1, 0, 0, 0);

        // Issue cancelled by a same-cycle jump
        cyc(); t_issue = 1; t_mc_dst = 5; t_mc_lat = 4; t_jmp = 1;
        push("jcancel", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("jc_b2", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("jc_b3", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("jc_end", 0, 0, 4'h0, 1, 0, 0, 0);

        // Flush bubble masks a pending load-use stall
        cyc(); t_jmp = 1; set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; t_ex_ld = 1;
        push("fl_j", 0, 1, 4'h0, 0, 0, 0, 0);
        cyc(); set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; t_ex_ld = 1;
        push("fl_2", 0, 1, 4'h0, 0, 0, 0, 1);
        cyc(); set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; t_ex_ld = 1;
        push("fl_3", 0, 1, 4'h0, 0, 0, 0, 1);
        cyc(); set_src(0, 5'd3); t_ex_vld = 1; t_ex_reg = 3; t_ex_ld = 1;
        push("fl_end", 1, 0, 4'h0, 0, 0, 0, 1);

        // Second jump reloads the flush counter
        cyc(); t_jmp = 1; push("rj_1", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); t_jmp = 1; push("rj_2", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("rj_3", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("rj_4", 0, 1, 4'h0, 1, 0, 0, 0);
        cyc(); push("rj_end", 0, 0, 4'h0, 1, 0, 0, 0);

        // Asynchronous reset while BUSY with cnt=2
        cyc(); t_issue = 1; t_mc_dst = 5; t_mc_lat = 4;
        push("rst_issue", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc(); push("rst_b1", 0, 0, 4'h0, 1, 1, 0, 0);
        cyc(); push("rst_b2", 0, 0, 4'h0, 1, 1, 0, 0);
        cyc();
        check("rst_pre_busy", bus_m.mc_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", bus_m.mc_busy, 0);
        check("rst_async_done", bus_m.mc_done, 0);
        push("rst_mid", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc(); push("rst_hold", 0, 0, 4'h0, 1, 0, 0, 0);
        cyc(); rst_n = 1'b1; set_src(0, 5'd5);
        push("rst_rel0", 0, 0, 4'h0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(); set_src(0, 5'd5);
            push("rst_relN", 0, 0, 4'h0, 1, 0, 0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/haz_fwd.md
Name: haz_fwd

Overview:
- Parametrised hazard unit for the 5-stage MIPS pipeline; successor to the stall-only hazard detector.
- Adds operand forwarding-select generation (EX/MEM/WB), load-use stall, a multi-cycle unit scoreboard (mul/div) with latency countdown FSM, and a configurable multi-cycle flush bubble after a taken jump resolved in MEM.
- Sits beside decode; drives decode stall/bubble, exec bubble and decode operand mux selects.

Parameters:
- REG_W, 5, register index width (NUM_REGS = 2**REG_W); index 0 is hard-wired zero.
- NUM_SRC, 2, decode source operands checked (rs, rt, ...).
- FWD_EN, 1, 1 = forward from EX/MEM/WB; 0 = stall on any match (legacy mode).
- LAT_W, 4, width of multi-cycle latency field/counter.
- FLUSH_CYC, 1, bubble cycles per taken jump (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_src_vld  in  NUM_SRC  per-source valid
- dec_src_reg  in  NUM_SRC*REG_W  per-source register index
- dec_mc_op  in  1  decode instruction targets the multi-cycle unit
- ex_dst_vld / ex_dst_reg / ex_is_load  in  1/REG_W/1  EX writer
- mem_dst_vld / mem_dst_reg  in  1/REG_W  MEM writer
- wb_dst_vld / wb_dst_reg  in  1/REG_W  WB writer
- mem_jmp_vld  in  1  taken jump/branch resolved in MEM
- mc_issue / mc_dst / mc_lat  in  1/REG_W/LAT_W  multi-cycle op leaving EX
- stall  out  1  hold PC and IF/ID
- dec_bubble  out  1  squash IF/ID
- ex_bubble  out  1  squash ID/EX
- fwd_sel  out  NUM_SRC*2  per source: 0 regfile, 1 EX, 2 MEM, 3 WB
- mc_busy  out  1  multi-cycle unit occupied
- mc_done  out  1  one-cycle pulse when result is written

Behaviour:
- Reset: FSM IDLE, counters 0; mc_busy=0, mc_done=0. stall/bubbles/fwd_sel combinational; 0 when inputs are 0.
- Match(src,stage) = src_vld & stage_vld & reg==stage_reg & reg!=0. Register 0 never hazards or forwards.
- FWD_EN=1: fwd_sel priority EX > MEM > WB > regfile. Match on EX with ex_is_load -> stall (load-use); fwd_sel for that source is don't-care.
- FWD_EN=0: any EX/MEM/WB match -> stall; fwd_sel always 0.
- MC FSM: IDLE -> BUSY on mc_issue & ~mem_jmp_vld (same-cycle jump cancels the younger op); cnt <= max(mc_lat,1), dst latched.
- BUSY: cnt decrements each cycle. At cnt==1: mc_done=1 that cycle, return to IDLE next cycle. mc_busy=1 throughout BUSY.
- BUSY: a source matching the latched dst (nonzero) stalls. dec_mc_op stalls (single unit). mc_issue while BUSY is a protocol error (assertion).
- mem_jmp_vld does not abort BUSY (op is older than the jump).
- Flush: bubble = mem_jmp_vld | (fcnt!=0). On mem_jmp_vld, fcnt <= FLUSH_CYC-1. Otherwise decrement to 0. A new jump while counting reloads.
- stall = raw_stall & ~bubble. dec_bubble = ex_bubble = bubble.
- rst_n low mid-BUSY: immediately IDLE, mc_busy=0, fcnt=0, no mc_done.

Decomposition:
- haz_pkg gains: fwd_sel_e enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), mc_state_e (IDLE, BUSY), and packet structs grouping the dec/ex/mem/wb fields above.
- Sub-module haz_mc_sb: multi-cycle FSM + counter + dst latch; outputs mc_busy, mc_done, busy_dst.
- Flush counter and match/priority logic stay in haz_fwd.

Test Plan:
- src0=r3; ex_dst=r3 (non-load), mem_dst=r3 -> fwd_sel[0]=1, stall=0. Drop EX -> 2. MEM also dropped, wb_dst=r3 -> 3.
- src1=r8; ex_dst=r8, ex_is_load=1 -> stall=1. Same with src1=r0 -> stall=0, fwd_sel=0. FWD_EN=0 build, mem_dst=r8 -> stall=1.
- mc_issue, mc_dst=r5, mc_lat=4 -> mc_busy for 4 cycles; mc_done on the 4th. src=r5 stalls during BUSY, not after. mc_lat=0 -> 1-cycle busy.
- BUSY + dec_mc_op=1 -> stall=1. mc_issue together with mem_jmp_vld -> FSM stays IDLE, bubble=1.
- FLUSH_CYC=3, single mem_jmp_vld pulse with an EX match present -> bubble=1 for 3 cycles, stall=0 during them. Second jump in cycle 2 -> bubble extends 3 more cycles.
- rst_n asserted mid-BUSY (cnt=2) -> mc_busy=0 asynchronously. No mc_done after release.
